// File: rtl/decode_pkg.sv
// decode_pkg: opcode encoding, flag table and per-slot decoded record shared by the decode stage.
package decode_pkg;
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ALU     = 4'd1,
        OP_ALU_IMM = 4'd2
    } opcode_e;

    localparam int F_WR_A = 0;
    localparam int F_WR_C = 1;
    localparam int F_RD_A = 2;
    localparam int F_RD_B = 3;

    // Tag storage is sized for the widest supported TAG_W; the stage uses the low TAG_W bits.
    localparam int TAG_MAX_W = 8;

    localparam logic [15:0] FLAG_TABLE [16] = '{
        16'h0000, 16'h801E, 16'h8016, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    typedef struct packed {
        logic                 mask;
        logic [1:0][4:0]      readregs;
        logic [4:0]           writereg;
        logic [7:0]           flags;
        logic [3:0]           fuid;
        logic [TAG_MAX_W-1:0] tag;
    } decoded_slot_t;
endpackage

// File: rtl/slot_decode.sv
// slot_decode: combinational decode of one 16-bit instruction through the flag table.
module slot_decode
    import decode_pkg::*;
(
    input  logic [15:0]   instr,
    output decoded_slot_t slot
);
    logic [15:0] f;

    always_comb begin
        f = FLAG_TABLE[instr[3:0]];
        slot = '0;
        slot.mask = 1'b1;
        slot.writereg = f[F_WR_A] ? {instr[15:12], 1'b1} : f[F_WR_C] ? {instr[7:4], 1'b1} : 5'd0;
        slot.readregs[0] = f[F_RD_A] ? {instr[15:12], 1'b1} : 5'd0;
        slot.readregs[1] = f[F_RD_B] ? {instr[11:8], 1'b1} : 5'd0;
        slot.flags = f[15:8];
        slot.fuid = f[7:4];
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered WIDTH-slot decode with sequence tagging, intra-group RAW flags
// and a one-entry skid buffer so in_ready comes straight from a flop.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int TAG_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_mask,
    input  logic [WIDTH*16-1:0]      in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_mask,
    output logic [WIDTH*10-1:0]      out_readregs,
    output logic [WIDTH*5-1:0]       out_writereg,
    output logic [WIDTH*8-1:0]       out_flags,
    output logic [WIDTH*4-1:0]       out_fuid,
    output logic [WIDTH*TAG_W-1:0]   out_tag,
    output logic [WIDTH*WIDTH-1:0]   out_dep
);
    decoded_slot_t            dec [WIDTH];
    decoded_slot_t            grp [WIDTH];
    decoded_slot_t            out_q [WIDTH];
    decoded_slot_t            skid_q [WIDTH];
    logic [WIDTH*WIDTH-1:0]   dep, dep_q, skid_dep_q;
    logic [TAG_W-1:0]         tag_q, cnt;
    logic                     out_v, skid_v, accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        slot_decode u_dec (.instr(in_instr[i*16 +: 16]), .slot(dec[i]));
    end

    // Masked slots are zeroed so they can never match in the dependency check.
    always_comb begin
        cnt = tag_q;
        dep = '0;
        for (int i = 0; i < WIDTH; i++) begin
            grp[i] = '0;
            if (in_mask[i]) begin
                grp[i] = dec[i];
                grp[i].tag = TAG_MAX_W'(cnt);
                cnt = cnt + TAG_W'(1);
            end
        end
        for (int j = 0; j < WIDTH; j++)
            for (int k = 0; k < j; k++)
                dep[j*WIDTH+k] = grp[j].mask && grp[k].mask && grp[k].writereg != 5'd0 &&
                    (grp[k].writereg == grp[j].readregs[0] || grp[k].writereg == grp[j].readregs[1]);
    end

    assign in_ready  = !skid_v;
    assign out_valid = out_v;
    assign accept    = in_valid && !skid_v && |in_mask && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v <= 1'b0;
            skid_v <= 1'b0;
            tag_q <= '0;
            out_q <= '{default: '0};
            dep_q <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            if (!out_v || out_ready) begin
                if (skid_v) begin
                    out_q <= skid_q;
                    dep_q <= skid_dep_q;
                    skid_v <= 1'b0;
                end else if (accept) begin
                    out_q <= grp;
                    dep_q <= dep;
                end
                out_v <= skid_v || accept;
            end else if (accept) begin
                skid_q <= grp;
                skid_dep_q <= dep;
                skid_v <= 1'b1;
            end
            if (accept) tag_q <= cnt;
        end
    end

    always_comb begin
        out_dep = dep_q;
        for (int i = 0; i < WIDTH; i++) begin
            out_mask[i] = out_q[i].mask;
            out_readregs[i*10 +: 10] = out_q[i].readregs;
            out_writereg[i*5 +: 5] = out_q[i].writereg;
            out_flags[i*8 +: 8] = out_q[i].flags;
            out_fuid[i*4 +: 4] = out_q[i].fuid;
            out_tag[i*TAG_W +: TAG_W] = out_q[i].tag[TAG_W-1:0];
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, tagging/wrap, RAW flags, skid backpressure, flush and reset.
module tb_decode_stage;
    localparam int WIDTH = 2;
    localparam int TAG_W = 2;

    logic                   clk = 1'b0;
    logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0]       in_mask, out_mask;
    logic [WIDTH*16-1:0]    in_instr;
    logic [WIDTH*10-1:0]    out_readregs;
    logic [WIDTH*5-1:0]     out_writereg;
    logic [WIDTH*8-1:0]     out_flags;
    logic [WIDTH*4-1:0]     out_fuid;
    logic [WIDTH*TAG_W-1:0] out_tag;
    logic [WIDTH*WIDTH-1:0] out_dep;
    int                     errors = 0;
    int                     checks = 0;

    decode_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_readregs(out_readregs), .out_writereg(out_writereg),
        .out_flags(out_flags), .out_fuid(out_fuid), .out_tag(out_tag), .out_dep(out_dep)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] mask, input logic [19:0] rr,
                           input logic [9:0] wr, input logic [15:0] fl, input logic [7:0] fu,
                           input logic [3:0] tg, input logic [3:0] dp);
        chk({name, ".valid"}, 64'(out_valid), 64'd1);
        chk({name, ".mask"}, 64'(out_mask), 64'(mask));
        chk({name, ".readregs"}, 64'(out_readregs), 64'(rr));
        chk({name, ".writereg"}, 64'(out_writereg), 64'(wr));
        chk({name, ".flags"}, 64'(out_flags), 64'(fl));
        chk({name, ".fuid"}, 64'(out_fuid), 64'(fu));
        chk({name, ".tag"}, 64'(out_tag), 64'(tg));
        chk({name, ".dep"}, 64'(out_dep), 64'(dp));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mask = '0; in_instr = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.fields", 64'({out_mask, out_readregs, out_writereg, out_flags, out_fuid, out_tag, out_dep}), 64'd0);

        // Single ALU in slot 0; slot 1 carries junk but is masked off.
        in_valid = 1'b1; in_mask = 2'b01; in_instr = {16'hFFFF, 16'h3451};
        tick();
        chk_all("alu", 2'b01, {10'd0, 5'd9, 5'd7}, {5'd0, 5'd11}, {8'h00, 8'h80}, {4'h0, 4'h1}, {2'd0, 2'd0}, 4'b0000);

        // Intra-group RAW: slot0 writes 7, slot1 reads 7; tags continue from 1.
        in_mask = 2'b11; in_instr = {16'h3452, 16'h1231};
        tick();
        chk_all("raw", 2'b11, {5'd0, 5'd7, 5'd5, 5'd3}, {5'd11, 5'd7}, {8'h80, 8'h80}, {4'h1, 4'h1}, {2'd2, 2'd1}, 4'b0100);

        // NOP and unknown opcode, and tag wraps 3 -> 0.
        in_instr = {16'hABCF, 16'hABC0};
        tick();
        chk_all("nop", 2'b11, 20'd0, 10'd0, 16'd0, 8'd0, {2'd0, 2'd3}, 4'b0000);

        // Empty mask with in_valid: consumed, no beat, no tag change.
        in_mask = 2'b00;
        tick();
        chk("mask0.out_valid", 64'(out_valid), 64'd0);
        in_mask = 2'b10; in_instr = {16'h3451, 16'h3451};
        tick();
        chk_all("slot1", 2'b10, {5'd9, 5'd7, 10'd0}, {5'd11, 5'd0}, {8'h80, 8'h00}, {4'h1, 4'h0}, {2'd1, 2'd0}, 4'b0000);

        // Backpressure: A fills OUT, B fills SKID, C is refused.
        in_valid = 1'b0;
        tick();
        chk("idle.out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 2'b01; in_instr = {16'h0000, 16'h1231};
        tick();
        chk("bpA.tag", 64'(out_tag), 64'({2'd0, 2'd2}));
        chk("bpA.in_ready", 64'(in_ready), 64'd1);
        in_instr = {16'h0000, 16'h3451};
        tick();
        chk("bpB.in_ready", 64'(in_ready), 64'd0);
        chk("bpB.hold_tag", 64'(out_tag), 64'({2'd0, 2'd2}));
        chk("bpB.hold_wr", 64'(out_writereg), 64'({5'd0, 5'd7}));
        in_instr = {16'h0000, 16'h0001};
        tick();
        chk("bpC.in_ready", 64'(in_ready), 64'd0);
        chk("bpC.hold_tag", 64'(out_tag), 64'({2'd0, 2'd2}));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain.valid", 64'(out_valid), 64'd1);
        chk("drain.tag", 64'(out_tag), 64'({2'd0, 2'd3}));
        chk("drain.wr", 64'(out_writereg), 64'({5'd0, 5'd11}));
        chk("drain.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("drain2.valid", 64'(out_valid), 64'd0);

        // Flush with OUT and SKID full keeps tag_q (now 3).
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 2'b11; in_instr = {16'h3451, 16'h1231};
        tick();
        chk("fD.tag", 64'(out_tag), 64'({2'd1, 2'd0}));
        in_mask = 2'b01;
        tick();
        chk("fE.in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("flushG.valid", 64'(out_valid), 64'd1);
        chk("flushG.tag", 64'(out_tag), 64'({2'd0, 2'd3}));

        // Reset with OUT and SKID full clears tag_q.
        out_ready = 1'b0;
        tick();
        chk("rH.in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1; in_mask = 2'b11;
        tick();
        chk("rstI.tag", 64'(out_tag), 64'({2'd1, 2'd0}));
        chk("rstI.valid", 64'(out_valid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
